hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard and stall controller for the 5-stage core. Sits beside the IF/ID, ID/EX and EX/MEM pipeline registers and drives their write-enable and flush controls. It resolves load-use hazards, holds EX for multi-cycle operations, and squashes wrong-path instructions on a taken branch. It also keeps saturating stall and flush performance counters.

## Interface
- REG_BITS, 5, width of register specifiers
- CNT_W, 4, width of the multi-cycle latency field and internal down-counter
- PERF_W, 16, width of each performance counter
- clk  in  1  core clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- id_rs, id_rt  in  REG_BITS each  source registers of the instruction in ID
- id_uses_rs, id_uses_rt  in  1 each  the ID instruction actually reads that source
- ex_reg  in  REG_BITS  destination register of the instruction in EX
- ex_mem_read  in  1  the EX instruction is a load
- ex_mc_start  in  1  the EX instruction is a multi-cycle op (mul/div)
- ex_mc_cycles  in  CNT_W  total EX occupancy N of that op, in cycles
- ex_branch_taken  in  1  the EX instruction is a resolved taken branch/jump
- pc_write  out  1  PC update enable
- if_id_write  out  1  IF/ID load enable
- if_id_flush  out  1  IF/ID loads a bubble
- id_ex_write  out  1  ID/EX load enable
- id_ex_flush  out  1  ID/EX loads a bubble; qualified by id_ex_write
- ex_mem_flush  out  1  EX/MEM loads a bubble
- mc_busy  out  1  multi-cycle hold in progress; high in MC state
- mc_done  out  1  one-cycle pulse on the release cycle of a multi-cycle op
- stall_count  out  PERF_W  saturating count of cycles with pc_write=0
- flush_count  out  PERF_W  saturating count of branch flushes

## Operation
- FSM states: RUN and MC. Down-counter cnt is CNT_W bits wide.
- Default outputs: all write enables 1, all flushes 0, mc_done 0.
- Load-use hazard (LU) is defined as ex_mem_read & (ex_reg != 0) & ((id_uses_rs & id_rs==ex_reg) | (id_uses_rt & id_rt==ex_reg)).
- RUN priority, highest first:
  - ex_mc_start with N>=2: pc_write=0, if_id_write=0, id_ex_write=0, ex_mem_flush=1. Next state MC, cnt<=N-1.
  - ex_branch_taken: if_id_flush=1, id_ex_flush=1; pc_write stays 1 so the redirect loads. flush_count increments.
  - LU: pc_write=0, if_id_write=0, id_ex_flush=1 (bubble into EX). Exactly one stall cycle.
- ex_mc_start with N of 0 or 1 is treated as single-cycle: no stall, no state change.
- MC state:
  - cnt decrements each cycle.
  - While cnt>1: same hold outputs as the start cycle.
  - When cnt==1 (release cycle): default outputs, mc_done=1, next state RUN.
- In MC, ex_mc_start, ex_branch_taken and LU are all ignored. The held EX instruction is the mc op itself.
- Net effect: an N-cycle op occupies EX for exactly N cycles and inserts N-1 bubbles into EX/MEM.
- Counters saturate at all-ones and never wrap.
- stall_count increments every cycle pc_write=0, including LU stalls and mc hold cycles.

## Timing
- All control outputs are combinational from the current state and inputs, valid in the same cycle.
- State, cnt and both counters are registered.
- Reset (sampled at the edge):
  - state<=RUN, cnt<=0, stall_count<=0, flush_count<=0.
  - While reset is high, outputs are forced to the defaults and mc_busy=0.
- Reset asserted mid-MC aborts the hold. The cycle after reset is deasserted is in RUN.
- A taken branch and LU in the same cycle: the branch wins and no stall is counted.
- ex_mc_start and ex_branch_taken in the same cycle: the mc op wins and the branch is ignored. The decoder guarantees this cannot occur.
- Back-to-back mc ops: the first cycle after release is in RUN, so a new ex_mc_start is accepted immediately.

## Test plan
- Load-use: ex_mem_read=1, ex_reg=5, id_rs=5, id_uses_rs=1 -> for exactly 1 cycle pc_write=0, if_id_write=0, id_ex_flush=1; stall_count=1.
- Register 0 and unused operand: ex_reg=0 with id_rs=0, or id_uses_rt=0 with id_rt==ex_reg -> no stall.
- Multi-cycle N=4: start pulse -> 3 hold cycles with id_ex_write=0 and ex_mem_flush=1, mc_busy high for 3 cycles, mc_done on cycle 4 with full enables; stall_count=3. N=1 and N=0 -> no stall.
- Branch taken with simultaneous LU -> if_id_flush=1, id_ex_flush=1, pc_write=1; flush_count=1, stall_count unchanged.
- Reset during MC (N=8, reset at hold cycle 2) -> next cycle all enables 1, mc_busy=0, both counters 0.
- Saturation: with PERF_W=4, hold 20 stall cycles -> stall_count stops at 15.

Source files
------------

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : Pipeline hazard and stall controller for the 5-stage core.
//            Drives write enables and flush controls of the IF/ID, ID/EX and
//            EX/MEM pipeline registers. Resolves load-use hazards, holds EX
//            for multi-cycle ops and squashes wrong-path instructions on a
//            taken branch. Keeps saturating stall and flush counters.
// Ports    : clk, reset              - clock, synchronous active-high reset
//            id_rs/id_rt/id_uses_*   - source operands of the ID instruction
//            ex_reg/ex_mem_read      - destination / load flag of EX instr
//            ex_mc_start/ex_mc_cycles- multi-cycle op start and occupancy N
//            ex_branch_taken         - resolved taken branch in EX
//            pc_write..ex_mem_flush  - pipeline register controls (comb.)
//            mc_busy/mc_done         - multi-cycle hold status
//            stall_count/flush_count - saturating performance counters
// Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
    parameter int REG_BITS = 5,
    parameter int CNT_W    = 4,
    parameter int PERF_W   = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [REG_BITS-1:0] id_rs,
    input  logic [REG_BITS-1:0] id_rt,
    input  logic                id_uses_rs,
    input  logic                id_uses_rt,
    input  logic [REG_BITS-1:0] ex_reg,
    input  logic                ex_mem_read,
    input  logic                ex_mc_start,
    input  logic [CNT_W-1:0]    ex_mc_cycles,
    input  logic                ex_branch_taken,
    output logic                pc_write,
    output logic                if_id_write,
    output logic                if_id_flush,
    output logic                id_ex_write,
    output logic                id_ex_flush,
    output logic                ex_mem_flush,
    output logic                mc_busy,
    output logic                mc_done,
    output logic [PERF_W-1:0]   stall_count,
    output logic [PERF_W-1:0]   flush_count
);

    localparam logic [CNT_W-1:0]  c_cnt_one  = CNT_W'(1);
    localparam logic [PERF_W-1:0] c_perf_max = '1;

    typedef enum logic [0:0] {
        ST_RUN = 1'b0,
        ST_MC  = 1'b1
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [PERF_W-1:0]   r_stall_count;
    logic [PERF_W-1:0]   r_flush_count;

    logic w_lu;
    logic w_mc_req;
    logic w_branch_flush;

    // Register 0 is hardwired to zero, so a load targeting it never hazards.
    assign w_lu = ex_mem_read & (ex_reg != '0) &
                  ((id_uses_rs & (id_rs == ex_reg)) |
                   (id_uses_rt & (id_rt == ex_reg)));

    // N of 0 or 1 completes in a single EX cycle and needs no hold.
    assign w_mc_req = ex_mc_start & (ex_mc_cycles > c_cnt_one);

    // Only a RUN-state branch that is not overridden by an mc start flushes.
    assign w_branch_flush = ~reset & (r_state == ST_RUN) & ~w_mc_req &
                            ex_branch_taken;

    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_write  = 1'b1;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        mc_busy      = 1'b0;
        mc_done      = 1'b0;
        if (!reset) begin
            case (r_state)
                ST_RUN: begin
                    if (w_mc_req) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_write  = 1'b0;
                        ex_mem_flush = 1'b1;
                    end else if (ex_branch_taken) begin
                        // pc_write stays high so the redirect target loads.
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (w_lu) begin
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        id_ex_flush = 1'b1;
                    end
                end
                ST_MC: begin
                    mc_busy = 1'b1;
                    // Hazard and branch inputs are ignored: EX holds the mc op.
                    if (r_cnt > c_cnt_one) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_write  = 1'b0;
                        ex_mem_flush = 1'b1;
                    end else begin
                        mc_done = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_RUN;
            r_cnt         <= '0;
            r_stall_count <= '0;
            r_flush_count <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_mc_req) begin
                        r_state <= ST_MC;
                        r_cnt   <= ex_mc_cycles - c_cnt_one;
                    end
                end
                ST_MC: begin
                    r_cnt <= r_cnt - c_cnt_one;
                    // <= rather than == so a corrupted zero count cannot lock up.
                    if (r_cnt <= c_cnt_one) begin
                        r_state <= ST_RUN;
                    end
                end
                default: r_state <= ST_RUN;
            endcase

            if (!pc_write && (r_stall_count != c_perf_max)) begin
                r_stall_count <= r_stall_count + 1'b1;
            end
            if (w_branch_flush && (r_flush_count != c_perf_max)) begin
                r_flush_count <= r_flush_count + 1'b1;
            end
        end
    end

    assign stall_count = r_stall_count;
    assign flush_count = r_flush_count;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_ctrl
// Purpose  : Self-checking bench for hazard_ctrl. Expected control vectors are
//            queued when stimulus is driven and popped when sampled.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    typedef logic [7:0] ctrl_t;
    // {pc_write, if_id_write, if_id_flush, id_ex_write,
    //  id_ex_flush, ex_mem_flush, mc_busy, mc_done}
    localparam ctrl_t C_DEF   = 8'b1101_0000;
    localparam ctrl_t C_LU    = 8'b0001_1000;
    localparam ctrl_t C_BR    = 8'b1111_1000;
    localparam ctrl_t C_HSTRT = 8'b0000_0100;
    localparam ctrl_t C_HMC   = 8'b0000_0110;
    localparam ctrl_t C_REL   = 8'b1101_0011;

    logic       clk;
    logic       reset;
    logic [4:0] id_rs, id_rt, ex_reg;
    logic       id_uses_rs, id_uses_rt, ex_mem_read, ex_mc_start, ex_branch_taken;
    logic [3:0] ex_mc_cycles;
    logic       pc_write, if_id_write, if_id_flush, id_ex_write;
    logic       id_ex_flush, ex_mem_flush, mc_busy, mc_done;
    logic [15:0] stall_count, flush_count;

    logic       s_pc_write, s_if_id_write, s_if_id_flush, s_id_ex_write;
    logic       s_id_ex_flush, s_ex_mem_flush, s_mc_busy, s_mc_done;
    logic [3:0] s_stall_count, s_flush_count;

    int    checks;
    int    errors;
    int    exp_stall;
    int    exp_flush;
    ctrl_t exp_q[$];
    ctrl_t got, e;

    hazard_ctrl dut (
        .clk(clk), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_reg(ex_reg), .ex_mem_read(ex_mem_read),
        .ex_mc_start(ex_mc_start), .ex_mc_cycles(ex_mc_cycles),
        .ex_branch_taken(ex_branch_taken),
        .pc_write(pc_write), .if_id_write(if_id_write),
        .if_id_flush(if_id_flush), .id_ex_write(id_ex_write),
        .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
        .mc_busy(mc_busy), .mc_done(mc_done),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    hazard_ctrl #(.PERF_W(4)) dut_sat (
        .clk(clk), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_reg(ex_reg), .ex_mem_read(ex_mem_read),
        .ex_mc_start(ex_mc_start), .ex_mc_cycles(ex_mc_cycles),
        .ex_branch_taken(ex_branch_taken),
        .pc_write(s_pc_write), .if_id_write(s_if_id_write),
        .if_id_flush(s_if_id_flush), .id_ex_write(s_id_ex_write),
        .id_ex_flush(s_id_ex_flush), .ex_mem_flush(s_ex_mem_flush),
        .mc_busy(s_mc_busy), .mc_done(s_mc_done),
        .stall_count(s_stall_count), .flush_count(s_flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic ctrl_t ctrl_now();
        return {pc_write, if_id_write, if_id_flush, id_ex_write,
                id_ex_flush, ex_mem_flush, mc_busy, mc_done};
    endfunction

    task automatic idle_inputs();
        id_rs = 5'd0; id_rt = 5'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
        ex_reg = 5'd0; ex_mem_read = 1'b0; ex_mc_start = 1'b0;
        ex_mc_cycles = 4'd0; ex_branch_taken = 1'b0;
    endtask

    task automatic set_lu_rs();
        ex_mem_read = 1'b1; ex_reg = 5'd5; id_rs = 5'd5; id_uses_rs = 1'b1;
    endtask

    // Entered and left at a falling edge; outputs sampled 2 ns after drive.
    task automatic test_reset();
        reset = 1'b1;
        set_lu_rs(); ex_branch_taken = 1'b1; ex_mc_start = 1'b1; ex_mc_cycles = 4'd4;
        exp_q.push_back(C_DEF);
        #2; e = exp_q.pop_front(); got = ctrl_now(); checks++;
        if (got !== e) begin errors++; $display("FAIL reset_ctrl got %b expected %b", got, e); end
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        reset = 1'b0;
        exp_stall = 0; exp_flush = 0;
        exp_q.push_back(C_DEF);
        #2; e = exp_q.pop_front(); got = ctrl_now(); checks++;
        if (got !== e) begin errors++; $display("FAIL post_reset_ctrl got %b expected %b", got, e); end
        checks++;
        if (stall_count !== 16'(exp_stall) || flush_count !== 16'(exp_flush)) begin
            errors++; $display("FAIL reset_counters got %0d/%0d expected 0/0", stall_count, flush_count);
        end
        @(negedge clk);
    endtask

    task automatic test_load_use();
        idle_inputs(); set_lu_rs();
        exp_q.push_back(C_LU);
        #2; e = exp_q.pop_front(); got = ctrl_now(); checks++;
        if (got !== e) begin errors++; $display("FAIL lu_rs_ctrl got %b expected %b", got, e); end
        exp_stall++;
        @(negedge clk);
        idle_inputs();
        exp_q.push_back(C_DEF);
        #2; e = exp_q.pop_front(); got = ctrl_now(); checks++;
        if (got !== e) begin errors++; $display("FAIL lu_release_ctrl got %b expected %b", got, e); end
        checks++;
        if (stall_count !== 16'(exp_stall)) begin
            errors++; $display("FAIL lu_stall_count got %0d expected %0d", stall_count, exp_stall);
        end
        @(negedge clk);
        // Load to register 0 never hazards.
        ex_mem_read = 1'b1; ex_reg = 5'd0; id_rs = 5'd0; id_uses_rs = 1'b1;
        exp_q.push_back(C_DEF);
        #2; e = exp_q.pop_front(); got = ctrl_now(); checks++;
        if (got !== e) begin errors++; $display("FAIL lu_reg0_ctrl got %b expected %b", got, e); end
        @(negedge clk);
        // Matching rt that the instruction does not read.
        idle_inputs(); ex_mem_read = 1'b1; ex_reg = 5'd9; id_rt = 5'd9; id_rs = 5'd3; id_uses_rs = 1'b1;
        exp_q.push_back(C_DEF);
        #2; e = exp_q.pop_front(); got = ctrl_now(); checks++;
        if (got !== e) begin errors++; $display("FAIL lu_unused_rt_ctrl got %b expected %b", got, e); end
        @(negedge clk);
        id_uses_rt = 1'b1;
        exp_q.push_back(C_LU);
        #2; e = exp_q.pop_front(); got = ctrl_now(); checks++;
        if (got !== e) begin errors++; $display("FAIL lu_rt_ctrl got %b expected %b", got, e); end
        exp_stall++;
        @(negedge clk);
        idle_inputs();
        checks++;
        if (stall_count !== 16'(exp_stall)) begin
            errors++; $display("FAIL lu_rt_stall_count got %0d expected %0d", stall_count, exp_stall);
        end
    endtask

    task automatic test_multicycle();
        // N=4: start hold, two MC holds, release; then N=2 back to back.
        idle_inputs(); ex_mc_start = 1'b1; ex_mc_cycles = 4'd4;
        exp_q.push_back(C_HSTRT); exp_q.push_back(C_HMC);
        exp_q.push_back(C_HMC);   exp_q.push_back(C_REL);
        exp_stall += 3;
        for (int i = 0; i < 4; i++) begin
            #2; e = exp_q.pop_front(); got = ctrl_now(); checks++;
            if (got !== e) begin errors++; $display("FAIL mc4_cycle%0d_ctrl got %b expected %b", i, got, e); end
            @(negedge clk);
            // Hazards and branches during the hold must be ignored.
            idle_inputs(); set_lu_rs(); ex_branch_taken = 1'b1;
        end
        idle_inputs(); ex_mc_start = 1'b1; ex_mc_cycles = 4'd2;
        exp_q.push_back(C_HSTRT); exp_q.push_back(C_REL);
        exp_stall += 1;
        for (int i = 0; i < 2; i++) begin
            #2; e = exp_q.pop_front(); got = ctrl_now(); checks++;
            if (got !== e) begin errors++; $display("FAIL mc2_b2b_cycle%0d_ctrl got %b expected %b", i, got, e); end
            @(negedge clk);
            idle_inputs();
        end
        checks++;
        if (stall_count !== 16'(exp_stall) || flush_count !== 16'(exp_flush)) begin
            errors++; $display("FAIL mc_counters got %0d/%0d expected %0d/%0d",
                               stall_count, flush_count, exp_stall, exp_flush);
        end
        for (int n = 1; n >= 0; n--) begin
            ex_mc_start = 1'b1; ex_mc_cycles = 4'(n);
            exp_q.push_back(C_DEF);
            #2; e = exp_q.pop_front(); got = ctrl_now(); checks++;
            if (got !== e) begin errors++; $display("FAIL mc_n%0d_ctrl got %b expected %b", n, got, e); end
            @(negedge clk);
        end
        idle_inputs();
        checks++;
        if (stall_count !== 16'(exp_stall)) begin
            errors++; $display("FAIL mc_short_stall_count got %0d expected %0d", stall_count, exp_stall);
        end
    endtask

    task automatic test_branch();
        idle_inputs(); set_lu_rs(); ex_branch_taken = 1'b1;
        exp_q.push_back(C_BR);
        exp_flush++;
        #2; e = exp_q.pop_front(); got = ctrl_now(); checks++;
        if (got !== e) begin errors++; $display("FAIL br_lu_ctrl got %b expected %b", got, e); end
        @(negedge clk);
        idle_inputs();
        checks++;
        if (stall_count !== 16'(exp_stall) || flush_count !== 16'(exp_flush)) begin
            errors++; $display("FAIL br_counters got %0d/%0d expected %0d/%0d",
                               stall_count, flush_count, exp_stall, exp_flush);
        end
        // mc start beats a simultaneous branch.
        ex_branch_taken = 1'b1; ex_mc_start = 1'b1; ex_mc_cycles = 4'd2;
        exp_q.push_back(C_HSTRT); exp_q.push_back(C_REL);
        exp_stall++;
        for (int i = 0; i < 2; i++) begin
            #2; e = exp_q.pop_front(); got = ctrl_now(); checks++;
            if (got !== e) begin errors++; $display("FAIL br_mc_cycle%0d_ctrl got %b expected %b", i, got, e); end
            @(negedge clk);
            idle_inputs();
        end
        checks++;
        if (stall_count !== 16'(exp_stall) || flush_count !== 16'(exp_flush)) begin
            errors++; $display("FAIL br_mc_counters got %0d/%0d expected %0d/%0d",
                               stall_count, flush_count, exp_stall, exp_flush);
        end
    endtask

    task automatic test_reset_mid_mc();
        idle_inputs(); ex_mc_start = 1'b1; ex_mc_cycles = 4'd8;
        exp_q.push_back(C_HSTRT); exp_q.push_back(C_HMC);
        for (int i = 0; i < 2; i++) begin
            #2; e = exp_q.pop_front(); got = ctrl_now(); checks++;
            if (got !== e) begin errors++; $display("FAIL mc8_cycle%0d_ctrl got %b expected %b", i, got, e); end
            @(negedge clk);
            idle_inputs();
        end
        reset = 1'b1;
        exp_q.push_back(C_DEF);
        #2; e = exp_q.pop_front(); got = ctrl_now(); checks++;
        if (got !== e) begin errors++; $display("FAIL mc8_in_reset_ctrl got %b expected %b", got, e); end
        @(negedge clk);
        reset = 1'b0;
        exp_stall = 0; exp_flush = 0;
        exp_q.push_back(C_DEF); exp_q.push_back(C_DEF);
        for (int i = 0; i < 2; i++) begin
            #2; e = exp_q.pop_front(); got = ctrl_now(); checks++;
            if (got !== e) begin errors++; $display("FAIL mc8_after_reset%0d_ctrl got %b expected %b", i, got, e); end
            checks++;
            if (stall_count !== 16'(exp_stall) || flush_count !== 16'(exp_flush)) begin
                errors++; $display("FAIL mc8_after_reset_counters got %0d/%0d expected 0/0",
                                   stall_count, flush_count);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_saturation();
        idle_inputs(); set_lu_rs();
        for (int i = 0; i < 20; i++) begin
            exp_q.push_back(C_LU);
            #2; e = exp_q.pop_front(); got = ctrl_now(); checks++;
            if (got !== e) begin errors++; $display("FAIL sat_cycle%0d_ctrl got %b expected %b", i, got, e); end
            exp_stall++;
            @(negedge clk);
        end
        idle_inputs();
        checks++;
        if (s_stall_count !== 4'd15) begin
            errors++; $display("FAIL sat_stall_count got %0d expected 15", s_stall_count);
        end
        checks++;
        if (stall_count !== 16'(exp_stall)) begin
            errors++; $display("FAIL wide_stall_count got %0d expected %0d", stall_count, exp_stall);
        end
    endtask

    initial begin
        checks = 0; errors = 0; exp_stall = 0; exp_flush = 0;
        reset = 1'b1;
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_load_use();
        test_multicycle();
        test_branch();
        test_reset_mid_mc();
        test_saturation();
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain got %0d entries expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
